// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: one-entry MEM/WB pipeline register that waits for the LSU
// response of a memory instruction, extends load data and holds the result
// until writeback consumes it.
// Optional feature macro: MEM_WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data
// forwarding outputs driven from the held entry.
module mem_wb_pipe #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_w_en,
    input  logic            in_mem_req,
    input  logic            in_is_load,
    input  logic [2:0]      in_ld_size,
    input  logic [2:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_exu_result,
    input  logic            lsu_resp_valid,
    input  logic [XLEN-1:0] lsu_resp_data,
    output logic            lsu_resp_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_rd_w_en,
    output logic [XLEN-1:0] out_x_rd
`ifdef MEM_WB_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            resp_take;
    logic            rd_w_en_q;
    logic            is_load_q;
    logic [2:0]      ld_size_q;
    logic [2:0]      addr_lo_q;
    logic [63:0]     resp_shift;
    logic [63:0]     ld_ext64;
    logic [XLEN-1:0] ld_ext;

    // Handshake outputs decoded from the registered state
    assign in_ready       = (state_q == S_EMPTY) | ((state_q == S_FULL) & out_ready);
    assign lsu_resp_ready = (state_q == S_WAIT) | (state_q == S_DRAIN);
    assign out_valid      = (state_q == S_FULL);
    assign out_rd_w_en    = out_valid & rd_w_en_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over acceptance and response
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        resp_take = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (!flush && in_valid) begin
                    accept  = 1'b1;
                    state_d = in_mem_req ? S_WAIT : S_FULL;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = lsu_resp_valid ? S_EMPTY : S_DRAIN;
                end else if (lsu_resp_valid) begin
                    resp_take = 1'b1;
                    state_d   = S_FULL;
                end
            end
            S_FULL: begin
                if (flush) begin
                    state_d = S_EMPTY;
                end else if (out_ready) begin
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = in_mem_req ? S_WAIT : S_FULL;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            S_DRAIN: begin
                if (lsu_resp_valid) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Load alignment and extension; truncation to XLEN=32 makes LD/LWU act as LW
    always_comb begin
        resp_shift = 64'(lsu_resp_data) >> {addr_lo_q, 3'b000};
        ld_ext64   = 64'd0;
        case (ld_size_q)
            3'd0: ld_ext64 = {{56{resp_shift[7]}}, resp_shift[7:0]};
            3'd1: ld_ext64 = {{48{resp_shift[15]}}, resp_shift[15:0]};
            3'd2: ld_ext64 = {{32{resp_shift[31]}}, resp_shift[31:0]};
            3'd3: ld_ext64 = resp_shift;
            3'd4: ld_ext64 = {56'd0, resp_shift[7:0]};
            3'd5: ld_ext64 = {48'd0, resp_shift[15:0]};
            3'd6: ld_ext64 = {32'd0, resp_shift[31:0]};
            default: ld_ext64 = 64'd0;
        endcase
        ld_ext = XLEN'(ld_ext64);
    end

    // Entry payload: captured on acceptance, result replaced by load data on response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pc    <= '0;
            out_rd    <= '0;
            rd_w_en_q <= 1'b0;
            is_load_q <= 1'b0;
            ld_size_q <= '0;
            addr_lo_q <= '0;
            out_x_rd  <= '0;
        end else if (accept) begin
            out_pc    <= in_pc;
            out_rd    <= in_rd;
            rd_w_en_q <= in_rd_w_en;
            is_load_q <= in_is_load;
            ld_size_q <= in_ld_size;
            addr_lo_q <= in_addr_lo;
            out_x_rd  <= in_exu_result;
        end else if (resp_take && is_load_q) begin
            out_x_rd  <= ld_ext;
        end
    end

`ifdef MEM_WB_FWD_EN
    // Forwarding view of a held entry that will write a nonzero register
    assign fwd_valid = out_rd_w_en & (out_rd != 5'd0);
    assign fwd_rd    = fwd_valid ? out_rd : 5'd0;
    assign fwd_data  = fwd_valid ? out_x_rd : '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: directed cases followed by random traffic
// checked against a transaction-level reference model.
module tb_mem_wb_pipe;

    localparam int unsigned XLEN = 64;
    localparam int unsigned PC_W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PC_W-1:0] in_pc = '0;
    logic [4:0]      in_rd = '0;
    logic            in_rd_w_en = 1'b0;
    logic            in_mem_req = 1'b0;
    logic            in_is_load = 1'b0;
    logic [2:0]      in_ld_size = '0;
    logic [2:0]      in_addr_lo = '0;
    logic [XLEN-1:0] in_exu_result = '0;
    logic            lsu_resp_valid = 1'b0;
    logic [XLEN-1:0] lsu_resp_data = '0;
    logic            lsu_resp_ready;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rd;
    logic            out_rd_w_en;
    logic [XLEN-1:0] out_x_rd;
`ifdef MEM_WB_FWD_EN
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
`endif

    mem_wb_pipe #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
        .in_rd_w_en(in_rd_w_en), .in_mem_req(in_mem_req), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_addr_lo(in_addr_lo), .in_exu_result(in_exu_result),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .lsu_resp_ready(lsu_resp_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
        .out_rd_w_en(out_rd_w_en), .out_x_rd(out_x_rd)
`ifdef MEM_WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic            wen;
        logic [XLEN-1:0] x;
    } exp_t;

    typedef enum int {M_EMPTY, M_WAIT, M_FULL, M_DRAIN} mst_t;

    exp_t sb[$];
    mst_t m_st = M_EMPTY;
    exp_t m_hold;
    logic m_load;
    logic [2:0] m_sz;
    logic [2:0] m_addr;
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Load result from the architectural rule: take N bytes at the byte offset, extend
    function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [2:0] sz,
                                              input logic [2:0] a);
        logic [63:0] s;
        logic [63:0] mask;
        int nbytes;
        bit sgn;
        s = d >> (int'(a) * 8);
        case (sz)
            3'd0: begin nbytes = 1; sgn = 1'b1; end
            3'd1: begin nbytes = 2; sgn = 1'b1; end
            3'd2: begin nbytes = 4; sgn = 1'b1; end
            3'd3: begin nbytes = 8; sgn = 1'b1; end
            3'd4: begin nbytes = 1; sgn = 1'b0; end
            3'd5: begin nbytes = 2; sgn = 1'b0; end
            3'd6: begin nbytes = 4; sgn = 1'b0; end
            default: return 64'd0;
        endcase
        if (nbytes == 8) return s;
        mask = (64'd1 << (nbytes * 8)) - 64'd1;
        if (sgn && s[nbytes * 8 - 1]) return (s & mask) | ~mask;
        return s & mask;
    endfunction

    function automatic bit model_in_ready(input mst_t st, input logic ordy);
        return (st == M_EMPTY) || (st == M_FULL && ordy);
    endfunction

    // Take a new instruction into the model slot
    task automatic model_take();
        m_hold.pc  = in_pc;
        m_hold.rd  = in_rd;
        m_hold.wen = in_rd_w_en;
        m_hold.x   = in_exu_result;
        m_load     = in_is_load;
        m_sz       = in_ld_size;
        m_addr     = in_addr_lo;
        if (in_mem_req) begin
            m_st = M_WAIT;
        end else begin
            sb.push_back(m_hold);
            m_st = M_FULL;
        end
    endtask

    // Reference model: decides per edge what the slot holds and what writeback will see
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = M_EMPTY;
            sb.delete();
        end else begin
            case (m_st)
                M_EMPTY: if (!flush && in_valid) model_take();
                M_WAIT: begin
                    if (flush) begin
                        m_st = lsu_resp_valid ? M_EMPTY : M_DRAIN;
                    end else if (lsu_resp_valid) begin
                        if (m_load) m_hold.x = ext_model(lsu_resp_data, m_sz, m_addr);
                        sb.push_back(m_hold);
                        m_st = M_FULL;
                    end
                end
                M_FULL: begin
                    if (flush) begin
                        if (!out_ready && sb.size() > 0) void'(sb.pop_back());
                        m_st = M_EMPTY;
                    end else if (out_ready) begin
                        if (in_valid) model_take();
                        else m_st = M_EMPTY;
                    end
                end
                M_DRAIN: if (lsu_resp_valid) m_st = M_EMPTY;
                default: m_st = M_EMPTY;
            endcase
        end
    end

    // Monitor: handshake checks each cycle, scoreboard pop on writeback consumption
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("out_valid", 64'(out_valid), 64'(m_st == M_FULL));
            chk("in_ready", 64'(in_ready), 64'(model_in_ready(m_st, out_ready)));
            chk("lsu_resp_ready", 64'(lsu_resp_ready), 64'(m_st == M_WAIT || m_st == M_DRAIN));
            if (!out_valid) chk("wen_gated", 64'(out_rd_w_en), 64'd0);
`ifdef MEM_WB_FWD_EN
            chk("fwd_valid", 64'(fwd_valid), 64'(out_valid && out_rd_w_en && out_rd != 5'd0));
            if (fwd_valid) chk("fwd_data", fwd_data, out_x_rd);
`endif
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got pc %h with no expected entry", out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc", 64'(out_pc), 64'(e.pc));
                    chk("out_rd", 64'(out_rd), 64'(e.rd));
                    chk("out_rd_w_en", 64'(out_rd_w_en), 64'(e.wen));
                    chk("out_x_rd", out_x_rd, e.x);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic mem, input logic ld, input logic [2:0] sz,
                             input logic [2:0] a, input logic [63:0] exu);
        in_valid      = 1'b1;
        in_pc         = $urandom;
        in_rd         = 5'($urandom_range(1, 31));
        in_rd_w_en    = 1'b1;
        in_mem_req    = mem;
        in_is_load    = ld;
        in_ld_size    = sz;
        in_addr_lo    = a;
        in_exu_result = exu;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_x_rd", out_x_rd, 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_resp_ready), 64'd0);
        repeat (2) step();

        // ALU op presented as reset releases, back-to-back second op
        set_instr(1'b0, 1'b0, 3'd0, 3'd0, 64'h1234);
        in_rd = 5'd5;
        rst = 1'b0;
        step();
        chk("alu_valid", 64'(out_valid), 64'd1);
        chk("alu_data", out_x_rd, 64'h1234);
        chk("alu_rd", 64'(out_rd), 64'd5);
        in_exu_result = 64'h5678;
        step();
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_data", out_x_rd, 64'h5678);

        // LB at offset 3 with a 4-cycle delayed response
        set_instr(1'b1, 1'b1, 3'd0, 3'd3, 64'h0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wait_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        lsu_resp_valid = 1'b1;
        lsu_resp_data  = 64'h0000_0000_8000_0000;
        step();
        lsu_resp_valid = 1'b0;
        chk("lb_valid", 64'(out_valid), 64'd1);
        chk("lb_data", out_x_rd, 64'hFFFF_FFFF_FFFF_FF80);

        // LBU same data
        set_instr(1'b1, 1'b1, 3'd4, 3'd3, 64'h0);
        step();
        in_valid       = 1'b0;
        lsu_resp_valid = 1'b1;
        step();
        lsu_resp_valid = 1'b0;
        chk("lbu_data", out_x_rd, 64'h80);

        // Flush in WAIT, response two cycles later is drained
        set_instr(1'b1, 1'b1, 3'd3, 3'd0, 64'h0);
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("drain_resp_ready", 64'(lsu_resp_ready), 64'd1);
        step();
        chk("drain_no_valid", 64'(out_valid), 64'd0);
        lsu_resp_valid = 1'b1;
        step();
        lsu_resp_valid = 1'b0;
        chk("drain_done_valid", 64'(out_valid), 64'd0);
        chk("drain_done_ready", 64'(in_ready), 64'd1);

        // FULL stalled three cycles
        out_ready = 1'b0;
        set_instr(1'b0, 1'b0, 3'd0, 3'd0, 64'hABC);
        step();
        in_exu_result = 64'hDEF;
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", out_x_rd, 64'hABC);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Reset while waiting for a response
        set_instr(1'b1, 1'b1, 3'd2, 3'd0, 64'h0);
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("rstw_out_valid", 64'(out_valid), 64'd0);
        chk("rstw_lsu_ready", 64'(lsu_resp_ready), 64'd0);
        chk("rstw_out_pc", 64'(out_pc), 64'd0);
        chk("rstw_out_x_rd", out_x_rd, 64'd0);
        step();
        rst = 1'b0;
        step();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid       = ($urandom_range(0, 99) < 60);
            in_pc          = $urandom;
            in_rd          = 5'($urandom);
            in_rd_w_en     = 1'($urandom);
            in_mem_req     = ($urandom_range(0, 99) < 45);
            in_is_load     = ($urandom_range(0, 99) < 70);
            in_ld_size     = 3'($urandom);
            in_addr_lo     = 3'($urandom);
            in_exu_result  = {$urandom, $urandom};
            lsu_resp_valid = ($urandom_range(0, 99) < 40);
            lsu_resp_data  = {$urandom, $urandom};
            flush          = ($urandom_range(0, 99) < 6);
            out_ready      = ($urandom_range(0, 99) < 70);
            step();
        end

        // Let everything retire
        in_valid       = 1'b0;
        flush          = 1'b0;
        out_ready      = 1'b1;
        lsu_resp_valid = 1'b1;
        repeat (6) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
